// File: rtl/sparc_ifu_lru_arb.sv
// N-requester LRU arbiter with hold mode and optional auto-update on acknowledged grant.
// Define SPARC_IFU_LRU_ARB_REG_GNT_EN to register grant_vec/grant_vld (1-cycle latency).
module sparc_ifu_lru_arb #(
    parameter int N        = 4,
    parameter int AUTO_UPD = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         se,
    input  logic         si,
    output logic         so,
    input  logic [N-1:0] req_vec,
    input  logic [N-1:0] spec_vec,
    input  logic         use_spec,
    input  logic [N-1:0] recent_vec,
    input  logic         load_recent,
    input  logic         gnt_ack,
    input  logic         hold,
    output logic [N-1:0] grant_vec,
    output logic         grant_vld
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] ord     [N];
    logic [N-1:0] ord_nxt [N];
    logic [N-1:0] held_gnt;
    logic         held_vld;
    logic [N-1:0] cand;
    logic [N-1:0] lru_gnt;
    logic [N-1:0] arb_gnt;
    logic [N-1:0] upd_sel;
    logic         ack_fire;
    logic         found;
    logic         seen;
    logic         unused_scan;

    // No scan chain is stitched through this block.
    assign so          = 1'b0;
    assign unused_scan = se ^ si;

    assign cand = use_spec ? spec_vec : req_vec;

    // The deepest matching row wins; a valid held grant overrides it.
    always_comb begin
        lru_gnt = '0;
        for (int k = 0; k < N; k++) begin
            if (|(ord[k] & cand)) lru_gnt = ord[k];
        end
        arb_gnt = (hold && held_vld && |(held_gnt & cand)) ? held_gnt : lru_gnt;
    end

`ifdef SPARC_IFU_LRU_ARB_REG_GNT_EN
    logic [N-1:0] gnt_q;

    always_ff @(posedge clk) begin
        if (reset) gnt_q <= '0;
        else       gnt_q <= arb_gnt;
    end

    assign grant_vec = gnt_q;
`else
    assign grant_vec = arb_gnt;
`endif

    assign grant_vld = |grant_vec;
    assign ack_fire  = gnt_ack & grant_vld;

    // Move the selected row to MRU; rows above it shift down by one.
    always_comb begin
        upd_sel = '0;
        if (load_recent)                   upd_sel = recent_vec & (~recent_vec + ONE);
        else if (AUTO_UPD != 0 && ack_fire) upd_sel = grant_vec;
        found   = |upd_sel;
        ord_nxt = ord;
        // NOTE: 'seen' is a blocking scratch flag; each iteration must see the previous one's value.
        seen    = |(ord[0] & upd_sel);
        for (int i = 1; i < N; i++) begin
            if (found && !seen) ord_nxt[i] = ord[i-1];
            if (|(ord[i] & upd_sel)) seen = 1'b1;
        end
        if (found) ord_nxt[0] = upd_sel;
    end

    // NOTE: the order array is real arbitration state and must start as a permutation, so it is reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) ord[i] <= ONE << i;
            held_gnt <= '0;
            held_vld <= 1'b0;
        end else begin
            ord <= ord_nxt;
            if (ack_fire) begin
                held_gnt <= grant_vec;
                held_vld <= 1'b1;
            end else if (!hold && !gnt_ack) begin
                held_gnt <= '0;
                held_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sparc_ifu_lru_arb.sv
// Directed scoreboard bench for sparc_ifu_lru_arb: a 4-way auto-update instance and an 8-way manual one.
module tb_sparc_ifu_lru_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, se, si;
    logic [3:0] a_req, a_spec, a_recent, a_gnt;
    logic       a_use_spec, a_load, a_ack, a_hold, a_vld, a_so;
    logic [7:0] b_req, b_spec, b_recent, b_gnt;
    logic       b_use_spec, b_load, b_ack, b_hold, b_vld, b_so;

    int passed = 0;
    int checks = 0;

    int         id_q  [$];
    string      tag_q [$];
    logic [7:0] gnt_q [$];
    logic       vld_q [$];

    sparc_ifu_lru_arb #(.N(4), .AUTO_UPD(1)) u_a (
        .clk(clk), .reset(reset), .se(se), .si(si), .so(a_so),
        .req_vec(a_req), .spec_vec(a_spec), .use_spec(a_use_spec),
        .recent_vec(a_recent), .load_recent(a_load), .gnt_ack(a_ack), .hold(a_hold),
        .grant_vec(a_gnt), .grant_vld(a_vld)
    );

    sparc_ifu_lru_arb #(.N(8), .AUTO_UPD(0)) u_b (
        .clk(clk), .reset(reset), .se(se), .si(si), .so(b_so),
        .req_vec(b_req), .spec_vec(b_spec), .use_spec(b_use_spec),
        .recent_vec(b_recent), .load_recent(b_load), .gnt_ack(b_ack), .hold(b_hold),
        .grant_vec(b_gnt), .grant_vld(b_vld)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_gnt(input int id, input string tag, input logic [7:0] g, input logic v);
        id_q.push_back(id);
        tag_q.push_back(tag);
        gnt_q.push_back(g);
        vld_q.push_back(v);
    endtask

    // Let combinational outputs settle, then compare every queued expectation.
    task automatic drain();
        int         id;
        string      tag;
        logic [7:0] g, obs;
        logic       v, obs_v;
        #1;
        while (tag_q.size() > 0) begin
            id    = id_q.pop_front();
            tag   = tag_q.pop_front();
            g     = gnt_q.pop_front();
            v     = vld_q.pop_front();
            obs   = (id == 0) ? {4'b0000, a_gnt} : b_gnt;
            obs_v = (id == 0) ? a_vld : b_vld;
            checks++;
            assert (obs === g && obs_v === v) passed++;
            else $error("FAIL %s: grant=%h vld=%b expected grant=%h vld=%b", tag, obs, obs_v, g, v);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; se = 1'b0; si = 1'b0;
        a_req = '0; a_spec = '0; a_recent = '0; a_use_spec = 0; a_load = 0; a_ack = 0; a_hold = 0;
        b_req = '0; b_spec = '0; b_recent = '0; b_use_spec = 0; b_load = 0; b_ack = 0; b_hold = 0;
        tick();
        do_reset();

`ifdef SPARC_IFU_LRU_ARB_REG_GNT_EN
        a_req = 4'b1111;
        b_req = 8'hFF;
        expect_gnt(0, "reg_lat0_a", 8'h00, 1'b0);
        expect_gnt(1, "reg_lat0_b", 8'h00, 1'b0);
        drain();
        tick();
        expect_gnt(0, "reg_lat1_a", 8'h08, 1'b1);
        expect_gnt(1, "reg_lat1_b", 8'h80, 1'b1);
        drain();
        // Ack of the registered grant reorders one cycle after that grant was computed.
        a_ack = 1'b1;
        b_ack = 1'b1;
        tick(); expect_gnt(0, "reg_ack1_a", 8'h08, 1'b1); expect_gnt(1, "reg_ack1_b", 8'h80, 1'b1); drain();
        tick(); expect_gnt(0, "reg_ack2_a", 8'h04, 1'b1); expect_gnt(1, "reg_ack2_b", 8'h80, 1'b1); drain();
        tick(); expect_gnt(0, "reg_ack3_a", 8'h04, 1'b1); expect_gnt(1, "reg_ack3_b", 8'h80, 1'b1); drain();
        tick(); expect_gnt(0, "reg_ack4_a", 8'h02, 1'b1); expect_gnt(1, "reg_ack4_b", 8'h80, 1'b1); drain();
        a_ack = 1'b0;
        b_ack = 1'b0;
`else
        // Round robin through auto-update.
        a_req = 4'b1111;
        expect_gnt(0, "rst_lru", 8'h08, 1'b1); drain();
        a_ack = 1'b1;
        tick(); expect_gnt(0, "rr1", 8'h04, 1'b1); drain();
        tick(); expect_gnt(0, "rr2", 8'h02, 1'b1); drain();
        tick(); expect_gnt(0, "rr3", 8'h01, 1'b1); drain();
        tick();
        a_ack = 1'b0;
        expect_gnt(0, "rr_wrap", 8'h08, 1'b1); drain();

        // load_recent reorders.
        do_reset();
        a_req = 4'b0011;
        expect_gnt(0, "req0011", 8'h02, 1'b1); drain();
        a_load = 1'b1; a_recent = 4'b0010;
        tick();
        a_load = 1'b0;
        expect_gnt(0, "load_recent", 8'h01, 1'b1); drain();

        // Speculative candidate selection and empty candidate set.
        a_use_spec = 1'b1; a_spec = 4'b0100; a_req = 4'b1000;
        expect_gnt(0, "spec_sel", 8'h04, 1'b1); drain();
        a_spec = 4'b0000;
        expect_gnt(0, "spec_none", 8'h00, 1'b0); drain();
        a_use_spec = 1'b0;

        // recent_vec boundary cases.
        do_reset();
        a_load = 1'b1; a_recent = 4'b1010;
        tick();
        a_load = 1'b0; a_req = 4'b0011;
        expect_gnt(0, "recent_multi", 8'h01, 1'b1); drain();
        a_load = 1'b1; a_recent = 4'b0000;
        tick();
        a_load = 1'b0;
        expect_gnt(0, "recent_zero", 8'h01, 1'b1); drain();
        a_load = 1'b1; a_recent = 4'b0010;
        tick();
        a_load = 1'b0; a_req = 4'b1111;
        expect_gnt(0, "recent_mru", 8'h08, 1'b1); drain();

        // Ack without a valid grant is ignored.
        a_req = 4'b0000; a_ack = 1'b1;
        tick();
        a_ack = 1'b0; a_req = 4'b1111;
        expect_gnt(0, "ack_novld", 8'h08, 1'b1); drain();

        // Hold mode.
        do_reset();
        a_req = 4'b1111;
        expect_gnt(0, "hold_pre", 8'h08, 1'b1); drain();
        a_ack = 1'b1; a_hold = 1'b1;
        tick();
        a_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_gnt(0, "hold_keep", 8'h08, 1'b1); drain();
            tick();
        end
        a_req = 4'b0111;
        expect_gnt(0, "hold_drop", 8'h04, 1'b1); drain();
        a_ack = 1'b1;
        tick();
        a_ack = 1'b0;
        expect_gnt(0, "hold_new", 8'h04, 1'b1); drain();
        do_reset();
        a_req = 4'b1111;
        expect_gnt(0, "rst_mid_hold", 8'h08, 1'b1); drain();
        a_hold = 1'b0;

        // load_recent and ack in the same cycle: load_recent owns the order.
        do_reset();
        a_req = 4'b1111;
        expect_gnt(0, "sc_pre", 8'h08, 1'b1); drain();
        a_load = 1'b1; a_recent = 4'b0001; a_ack = 1'b1;
        tick();
        a_load = 1'b0; a_ack = 1'b0;
        expect_gnt(0, "sc_unmoved", 8'h08, 1'b1); drain();
        a_req = 4'b0011;
        expect_gnt(0, "sc_order", 8'h02, 1'b1); drain();

        // 8-way without auto-update.
        do_reset();
        b_req = 8'hFF;
        expect_gnt(1, "b_rst", 8'h80, 1'b1); drain();
        b_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_gnt(1, "b_noupd", 8'h80, 1'b1); drain();
        end
        b_ack = 1'b0; b_load = 1'b1; b_recent = 8'h80;
        tick();
        b_load = 1'b0;
        expect_gnt(1, "b_load", 8'h40, 1'b1); drain();
        do_reset();
        expect_gnt(1, "b_rst_mid", 8'h80, 1'b1); drain();
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
